// File: rtl/nios_cpu_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared OCI trace constants: direct-control-transfer code values, accumulator geometry,
// and the frame slot state encoding used by the DCT packer.
package nios_cpu_nios2_qsys_0_oci_dct_packer_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_DEPTH  = 15;
  localparam int DCT_BUF_W  = DCT_CODE_W * DCT_DEPTH;
  localparam int DCT_CNT_W  = 4;

  typedef logic [DCT_CODE_W-1:0] dct_code_t;

  localparam dct_code_t DCT_ILLEGAL   = 2'b00;
  localparam dct_code_t DCT_NOT_TAKEN = 2'b01;
  localparam dct_code_t DCT_TAKEN     = 2'b10;
  localparam dct_code_t DCT_CALL      = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/nios_cpu_nios2_qsys_0_oci_dct_packer_if.sv
// Frame output handshake toward the downstream trace FIFO: the packer is master,
// the FIFO (or bench) is slave and returns out_ready.
interface nios_cpu_nios2_qsys_0_oci_dct_packer_if;
  import nios_cpu_nios2_qsys_0_oci_dct_packer_pkg::*;

  logic                 frame_valid;
  logic [DCT_BUF_W-1:0] frame_buffer;
  logic [DCT_CNT_W-1:0] frame_count;
  logic                 out_ready;

  modport master (output frame_valid, output frame_buffer, output frame_count, input out_ready);
  modport slave  (input frame_valid, input frame_buffer, input frame_count, output out_ready);

endinterface

// File: rtl/nios_cpu_nios2_qsys_0_oci_dct_frame_slot.sv
// Single-entry frame slot: frame visible 1 clk after emit; a new frame arriving while
// the slot is full and out_ready is low is dropped and counted (old frame kept).
module nios_cpu_nios2_qsys_0_oci_dct_frame_slot
  import nios_cpu_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  emit,
  input  logic [DCT_BUF_W-1:0]  cand_buffer,
  input  logic [DCT_CNT_W-1:0]  cand_count,
  input  logic                  out_ready,
  output logic                  frame_valid,
  output logic [DCT_BUF_W-1:0]  frame_buffer,
  output logic [DCT_CNT_W-1:0]  frame_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  slot_state_t state_q, state_d;
  logic        load;
  logic        drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SLOT_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (emit) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !emit) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // A full slot only takes a new frame in the same cycle the old one is consumed.
  always_comb begin
    frame_valid = (state_q == SLOT_FULL);
    load        = emit && ((state_q == SLOT_EMPTY) || out_ready);
    drop        = emit && (state_q == SLOT_FULL) && !out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_buffer <= '0;
      frame_count  <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (load) begin
        frame_buffer <= cand_buffer;
        frame_count  <= cand_count;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nios_cpu_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit direct-control-transfer codes into 15-entry trace frames; frame 1 clk after
// the closing code/flush. Backpressure: one-frame slot, overflowing frames dropped and counted.
module nios_cpu_nios2_qsys_0_oci_dct_packer
  import nios_cpu_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trc_on,
  input  logic                  dct_valid,
  input  logic [DCT_CODE_W-1:0] dct_code,
  input  logic                  flush,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  nios_cpu_nios2_qsys_0_oci_dct_packer_if.master frm
);

  logic                 trc_prev;
  logic                 trc_fall;
  logic                 do_insert;
  logic                 do_emit;
  logic [DCT_BUF_W-1:0] post_buf;
  logic [DCT_CNT_W-1:0] post_cnt;

  // Trace switching off closes the partial frame; trc_on is already low, so no insert.
  always_comb begin
    trc_fall  = trc_prev && !trc_on;
    do_insert = trc_on && dct_valid && (dct_code != DCT_ILLEGAL);
    post_buf  = dct_buffer;
    post_cnt  = dct_count;
    if (do_insert) begin
      post_buf = {dct_buffer[DCT_BUF_W-DCT_CODE_W-1:0], dct_code};
      post_cnt = dct_count + DCT_CNT_W'(1);
    end
    do_emit = (post_cnt == DCT_CNT_W'(DCT_DEPTH)) ||
              ((flush || trc_fall) && (post_cnt != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trc_prev   <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      trc_prev <= trc_on;
      if (do_emit) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else begin
        dct_buffer <= post_buf;
        dct_count  <= post_cnt;
      end
    end
  end

  nios_cpu_nios2_qsys_0_oci_dct_frame_slot #(
    .DROP_CNT_W (DROP_CNT_W)
  ) u_frame_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .emit         (do_emit),
    .cand_buffer  (post_buf),
    .cand_count   (post_cnt),
    .out_ready    (frm.out_ready),
    .frame_valid  (frm.frame_valid),
    .frame_buffer (frm.frame_buffer),
    .frame_count  (frm.frame_count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

endmodule

// File: tb/tb_nios_cpu_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus random traffic against a queue-based model.
module tb_nios_cpu_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trc_on = 1'b0;
  logic        dct_valid = 1'b0;
  logic [1:0]  dct_code = 2'b00;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  nios_cpu_nios2_qsys_0_oci_dct_packer_if frm_if ();

  nios_cpu_nios2_qsys_0_oci_dct_packer #(.DROP_CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush      (flush),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .frm        (frm_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending codes, the held frame's codes, and sticky drop bookkeeping.
  int q[$];
  int mf[$];
  bit m_full, m_ovf, m_prev;
  int m_drops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_live();
    logic [31:0] v = 0;
    foreach (q[i]) v = (v << 2) | 32'(q[i]);
    return v;
  endfunction

  function automatic logic [31:0] pack_frame();
    logic [31:0] v = 0;
    foreach (mf[i]) v = (v << 2) | 32'(mf[i]);
    return v;
  endfunction

  task automatic model_reset();
    q.delete(); mf.delete();
    m_full = 0; m_ovf = 0; m_prev = 0; m_drops = 0;
  endtask

  task automatic model_step(input bit trc, input bit vld, input bit [1:0] code,
                            input bit fl, input bit rdy);
    bit fall, emit;
    fall = m_prev && !trc;
    if (trc && vld && code != 2'b00) q.push_back(int'(code));
    emit = (q.size() == 15) || ((fl || fall) && q.size() > 0);
    if (emit) begin
      if (!m_full || rdy) begin
        mf = q;
        m_full = 1;
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      q.delete();
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    m_prev = trc;
  endtask

  task automatic compare_all();
    check_eq("dct_buffer", 32'(dct_buffer), pack_live());
    check_eq("dct_count", 32'(dct_count), 32'(q.size()));
    check_eq("frame_valid", 32'(frm_if.frame_valid), 32'(m_full));
    check_eq("frame_count", 32'(frm_if.frame_count), 32'(mf.size()));
    check_eq("frame_buffer", 32'(frm_if.frame_buffer), pack_frame());
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // Called just after a rising edge; drives, advances one clock, then samples 1 time unit later.
  task automatic step(input bit trc, input bit vld, input bit [1:0] code,
                      input bit fl, input bit rdy);
    trc_on = trc; dct_valid = vld; dct_code = code; flush = fl; frm_if.out_ready = rdy;
    @(posedge clk);
    model_step(trc, vld, code, fl, rdy);
    #1;
    compare_all();
  endtask

  // Asserted between edges so the asynchronous clear is observed without a clock.
  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    check_eq("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    check_eq("rst_dct_count", 32'(dct_count), 32'd0);
    check_eq("rst_frame_valid", 32'(frm_if.frame_valid), 32'd0);
    check_eq("rst_frame_buffer", 32'(frm_if.frame_buffer), 32'd0);
    check_eq("rst_frame_count", 32'(frm_if.frame_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    model_reset();
    trc_on = 1'b0; dct_valid = 1'b0; dct_code = 2'b00; flush = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    frm_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Full frame of 15 taken codes.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(1, 1, 2'b10, 0, 1);
    check_eq("full_valid", 32'(frm_if.frame_valid), 32'd1);
    check_eq("full_count", 32'(frm_if.frame_count), 32'd15);
    check_eq("full_buffer", 32'(frm_if.frame_buffer), 32'h2AAAAAAA);
    check_eq("full_dct_count", 32'(dct_count), 32'd0);
    step(1, 0, 0, 0, 1);
    check_eq("full_consumed", 32'(frm_if.frame_valid), 32'd0);

    // Three codes then a flush.
    step(1, 1, 2'b01, 0, 1);
    step(1, 1, 2'b10, 0, 1);
    step(1, 1, 2'b11, 0, 1);
    step(1, 0, 0, 1, 1);
    check_eq("flush3_count", 32'(frm_if.frame_count), 32'd3);
    check_eq("flush3_buffer", 32'(frm_if.frame_buffer), 32'h1B);
    step(1, 0, 0, 1, 1);
    check_eq("flush3_single", 32'(frm_if.frame_valid), 32'd0);

    // Code and flush together from empty.
    step(1, 1, 2'b01, 1, 1);
    check_eq("cf_count", 32'(frm_if.frame_count), 32'd1);
    check_eq("cf_buffer", 32'(frm_if.frame_buffer), 32'h1);
    step(1, 0, 0, 0, 1);

    // Overflow: second frame dropped while the first is held.
    apply_reset();
    step(1, 1, 2'b10, 0, 0);
    step(1, 1, 2'b01, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 2'b11, 0, 0);
    step(1, 0, 0, 1, 0);
    check_eq("ovf_count", 32'(frm_if.frame_count), 32'd2);
    check_eq("ovf_buffer", 32'(frm_if.frame_buffer), 32'h9);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drops", 32'(drop_cnt), 32'd1);

    // Trace switched off with five pending codes.
    apply_reset();
    step(1, 0, 0, 0, 1);
    step(1, 1, 2'b01, 0, 1);
    step(1, 1, 2'b10, 0, 1);
    step(1, 1, 2'b11, 0, 1);
    step(1, 1, 2'b01, 0, 1);
    step(1, 1, 2'b10, 0, 1);
    step(0, 1, 2'b11, 0, 1);
    check_eq("trcoff_count", 32'(frm_if.frame_count), 32'd5);
    check_eq("trcoff_buffer", 32'(frm_if.frame_buffer), 32'h1B6);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b10, 0, 1);
    check_eq("trcoff_ignored", 32'(dct_count), 32'd0);

    // Reset while holding a frame and seven pending codes.
    apply_reset();
    step(1, 1, 2'b01, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 2'b11, 0, 0);
    check_eq("midrst_count", 32'(dct_count), 32'd7);
    check_eq("midrst_full", 32'(frm_if.frame_valid), 32'd1);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1);
      check_eq("midrst_noframe", 32'(frm_if.frame_valid), 32'd0);
    end

    // Drop counter saturation.
    apply_reset();
    step(1, 1, 2'b01, 1, 0);
    for (int i = 0; i < 260; i++) step(1, 1, 2'b10, 1, 0);
    check_eq("sat_drops", 32'(drop_cnt), 32'd255);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step($urandom_range(0, 19) != 0,
                $urandom_range(0, 9) < 7,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
